reservation_station: RTL

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/tomas_pkg.sv | 37 +++
 rtl/rs_entry.sv | 44 ++++
 rtl/reservation_station.sv | 133 +++++++++++++
 3 files changed

// File: rtl/tomas_pkg.sv
// Shared widths, entry record and helper functions for the Tomasulo-style
// reservation station. Imported by rs_entry and reservation_station.
package tomas_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;
    localparam int TAG_W  = 3;
    localparam int OP_W   = 3;

    // Tag value meaning "operand already holds its value".
    localparam logic [TAG_W-1:0] TAG_NONE = 3'd0;

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
    } rs_entry_t;

    localparam int ENTRY_W = $bits(rs_entry_t);

    // A broadcast satisfies a waiting operand only for a real (nonzero) tag.
    function automatic logic cdb_match(input logic             valid,
                                       input logic [TAG_W-1:0] cdb_tag,
                                       input logic [TAG_W-1:0] q);
        return valid && (cdb_tag != TAG_NONE) && (cdb_tag == q);
    endfunction

    // An entry may dispatch once it is occupied and both operands are present.
    function automatic logic entry_ready(input rs_entry_t e);
        return e.busy && (e.qj == TAG_NONE) && (e.qk == TAG_NONE);
    endfunction

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: holds an issued instruction and captures
// missing operands from the common data bus.
module rs_entry
    import tomas_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               alloc,
    input  logic [ENTRY_W-1:0] alloc_entry,
    input  logic               free,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    input  logic [DATA_W-1:0]  cdb_data,
    output logic [ENTRY_W-1:0] entry
);

    rs_entry_t ent_r;
    rs_entry_t alloc_s;

    assign alloc_s = alloc_entry;
    assign entry   = ent_r;

    // Slot state: reset wins, then allocation, otherwise dispatch-free and wakeup.
    always_ff @(posedge clock) begin
        if (reset) begin
            ent_r <= '0;
        end else if (alloc) begin
            ent_r <= alloc_s;
        end else begin
            if (free) begin
                ent_r.busy <= 1'b0;
            end
            if (ent_r.busy && cdb_match(cdb_valid, cdb_tag, ent_r.qj)) begin
                ent_r.vj <= cdb_data;
                ent_r.qj <= TAG_NONE;
            end
            if (ent_r.busy && cdb_match(cdb_valid, cdb_tag, ent_r.qk)) begin
                ent_r.vk <= cdb_data;
                ent_r.qk <= TAG_NONE;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: DEPTH slots, lowest-free allocation, lowest-ready
// dispatch. Entry i owns tag TAG_BASE+i.
// Optional macro RS_ISSUE_FORWARD_EN: capture a same-cycle CDB broadcast at
// issue; without it, issue is held off whenever the CDB is active.
module reservation_station
    import tomas_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int TAG_BASE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [REG_W-1:0]  issue_dest,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [TAG_W-1:0]  issue_qk,
    output logic [TAG_W-1:0]  issue_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              disp_valid,
    input  logic              disp_ready,
    output logic [OP_W-1:0]   disp_op,
    output logic [DATA_W-1:0] disp_a,
    output logic [DATA_W-1:0] disp_b,
    output logic [TAG_W-1:0]  disp_tag,
    output logic [REG_W-1:0]  disp_dest
);

    rs_entry_t          ent_s      [DEPTH];
    logic [ENTRY_W-1:0] ent_bits_s [DEPTH];
    logic [DEPTH-1:0]   busy_s;
    logic [DEPTH-1:0]   ready_s;
    logic [DEPTH-1:0]   alloc_s;
    logic [DEPTH-1:0]   free_s;
    rs_entry_t          alloc_entry_s;
    logic               free_any_s;
    logic               fire_issue_s;
    logic [TAG_W-1:0]   free_idx_s;
    logic [TAG_W-1:0]   sel_idx_s;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        rs_entry u_entry (
            .clock       (clock),
            .reset       (reset),
            .alloc       (alloc_s[i]),
            .alloc_entry (alloc_entry_s),
            .free        (free_s[i]),
            .cdb_valid   (cdb_valid),
            .cdb_tag     (cdb_tag),
            .cdb_data    (cdb_data),
            .entry       (ent_bits_s[i])
        );
        assign ent_s[i]   = ent_bits_s[i];
        assign busy_s[i]  = ent_s[i].busy;
        assign ready_s[i] = entry_ready(ent_s[i]);
    end

    // Build the record written into the allocated slot, forwarding the CDB if enabled.
    always_comb begin
        alloc_entry_s      = '0;
        alloc_entry_s.busy = 1'b1;
        alloc_entry_s.op   = issue_op;
        alloc_entry_s.dest = issue_dest;
`ifdef RS_ISSUE_FORWARD_EN
        if (cdb_match(cdb_valid, cdb_tag, issue_qj)) begin
            alloc_entry_s.vj = cdb_data;
            alloc_entry_s.qj = TAG_NONE;
        end else begin
            alloc_entry_s.vj = issue_vj;
            alloc_entry_s.qj = issue_qj;
        end
        if (cdb_match(cdb_valid, cdb_tag, issue_qk)) begin
            alloc_entry_s.vk = cdb_data;
            alloc_entry_s.qk = TAG_NONE;
        end else begin
            alloc_entry_s.vk = issue_vk;
            alloc_entry_s.qk = issue_qk;
        end
`else
        alloc_entry_s.vj = issue_vj;
        alloc_entry_s.qj = issue_qj;
        alloc_entry_s.vk = issue_vk;
        alloc_entry_s.qk = issue_qk;
`endif
    end

    // Allocation: lowest free slot from registered busy bits only, so a slot
    // freed by this cycle's dispatch is not handed out until next cycle.
    always_comb begin
        free_any_s = ~&busy_s;
        free_idx_s = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            free_idx_s = busy_s[i] ? free_idx_s : TAG_W'(i);
        end
`ifdef RS_ISSUE_FORWARD_EN
        issue_ready = free_any_s;
`else
        issue_ready = free_any_s && !cdb_valid;
`endif
        issue_tag    = free_any_s ? (TAG_W'(TAG_BASE) + free_idx_s) : TAG_NONE;
        fire_issue_s = issue_valid && issue_ready;
        for (int i = 0; i < DEPTH; i++) begin
            alloc_s[i] = fire_issue_s && (free_idx_s == TAG_W'(i));
        end
    end

    // Dispatch: lowest-index ready slot drives the outputs; zeros when idle.
    always_comb begin
        sel_idx_s = '0;
        disp_op   = '0;
        disp_dest = '0;
        disp_a    = '0;
        disp_b    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            sel_idx_s = ready_s[i] ? TAG_W'(i)     : sel_idx_s;
            disp_op   = ready_s[i] ? ent_s[i].op   : disp_op;
            disp_dest = ready_s[i] ? ent_s[i].dest : disp_dest;
            disp_a    = ready_s[i] ? ent_s[i].vj   : disp_a;
            disp_b    = ready_s[i] ? ent_s[i].vk   : disp_b;
        end
        disp_valid = |ready_s;
        disp_tag   = disp_valid ? (TAG_W'(TAG_BASE) + sel_idx_s) : TAG_NONE;
        for (int i = 0; i < DEPTH; i++) begin
            free_s[i] = disp_valid && disp_ready && (sel_idx_s == TAG_W'(i));
        end
    end

endmodule
